// File: rtl/vga_pkg.sv
// Shared types and helpers for the VGA raster address generator.
package vga_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } vga_state_t;

    localparam int DEFAULT_H_ACTIVE = 640;
    localparam int DEFAULT_V_ACTIVE = 480;

    function automatic int frame_pixels(input int h_active, input int v_active);
        return h_active * v_active;
    endfunction

    // A one-entry axis still needs a one-bit coordinate.
    function automatic int coord_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vga_raster_addr_gen_if.sv
// Pixel stream from the raster address generator to the frame-buffer read port.
// Handshake: a beat transfers on a rising clock edge where out_valid and out_ready are both high;
// while out_valid is high and out_ready is low, every other field holds stable.
interface vga_raster_addr_gen_if #(
    parameter int ADDR_W = 20,
    parameter int X_W    = 10,
    parameter int Y_W    = 9
);
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] read_address;
    logic [X_W-1:0]    x;
    logic [Y_W-1:0]    y;
    logic              sof;
    logic              eol;
    logic              eof;

    modport master (
        output out_valid, read_address, x, y, sof, eol, eof,
        input  out_ready
    );

    modport slave (
        input  out_valid, read_address, x, y, sof, eol, eof,
        output out_ready
    );
endinterface

// File: rtl/vga_axis_counter.sv
// Wrap-around coordinate counter: counts 0..MAX-1, wrap flags the last value.
module vga_axis_counter #(
    parameter int MAX = 4,
    parameter int W   = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         wrap
);

    assign wrap = (count == W'(MAX - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= wrap ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/vga_raster_addr_gen.sv
// Raster-order frame-buffer address generator with SOF/EOL/EOF markers.
// Build option VGA_RASTER_DOUBLE_BUFFER_EN: ping-pong between two frame buffers.
module vga_raster_addr_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE  = DEFAULT_H_ACTIVE,
    parameter int V_ACTIVE  = DEFAULT_V_ACTIVE,
    parameter int ADDR_W    = 20,
    parameter int BASE_ADDR = 0,
    parameter int FCNT_W    = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  continuous,
    input  logic                  abort,
    vga_raster_addr_gen_if.master pix,
    output logic [FCNT_W-1:0]     frame_count,
    output logic                  buf_sel,
    output vga_state_t            state
);

    localparam int FRAME_PIXELS = frame_pixels(H_ACTIVE, V_ACTIVE);
    localparam int X_W          = coord_w(H_ACTIVE);
    localparam int Y_W          = coord_w(V_ACTIVE);
    localparam logic [ADDR_W-1:0] BASE0 = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] BASE1 = ADDR_W'(BASE_ADDR + FRAME_PIXELS);

    logic              valid;
    logic [ADDR_W-1:0] address;
    logic [X_W-1:0]    x;
    logic [Y_W-1:0]    y;
    logic              x_wrap;
    logic              y_wrap;
    logic              accept;
    logic              last_pixel;
    logic              next_buf;

    assign accept     = valid & pix.out_ready;
    assign last_pixel = x_wrap & y_wrap;

    // Abort clears both axes; a completed frame wraps them back to zero on its own.
    vga_axis_counter #(.MAX(H_ACTIVE), .W(X_W)) u_x_counter (
        .clock (clock),
        .reset (reset),
        .clear (abort),
        .inc   (accept),
        .count (x),
        .wrap  (x_wrap)
    );

    vga_axis_counter #(.MAX(V_ACTIVE), .W(Y_W)) u_y_counter (
        .clock (clock),
        .reset (reset),
        .clear (abort),
        .inc   (accept & x_wrap),
        .count (y),
        .wrap  (y_wrap)
    );

`ifdef VGA_RASTER_DOUBLE_BUFFER_EN
    assign next_buf = ~buf_sel;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            buf_sel <= 1'b0;
        end else if (!abort && state == RUN && accept && last_pixel) begin
            buf_sel <= next_buf;
        end
    end
`else
    assign next_buf = 1'b0;
    assign buf_sel  = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            valid       <= 1'b0;
            address     <= BASE0;
            frame_count <= '0;
        end else if (abort) begin
            state   <= IDLE;
            valid   <= 1'b0;
            address <= buf_sel ? BASE1 : BASE0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= RUN;
                        valid   <= 1'b1;
                        address <= buf_sel ? BASE1 : BASE0;
                    end
                end
                RUN: begin
                    if (accept) begin
                        if (last_pixel) begin
                            frame_count <= frame_count + 1'b1;
                            address     <= next_buf ? BASE1 : BASE0;
                            if (!continuous) begin
                                state <= IDLE;
                                valid <= 1'b0;
                            end
                        end else begin
                            address <= address + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    valid <= 1'b0;
                end
            endcase
        end
    end

    assign pix.out_valid    = valid;
    assign pix.read_address = address;
    assign pix.x            = x;
    assign pix.y            = y;
    assign pix.sof          = valid & (x == '0) & (y == '0);
    assign pix.eol          = valid & x_wrap;
    assign pix.eof          = valid & x_wrap & y_wrap;

endmodule

// File: tb/tb_vga_raster_addr_gen.sv
// Directed bench for vga_raster_addr_gen with a 4x3 frame.
module tb_vga_raster_addr_gen;
  import vga_pkg::*;

  localparam int H    = 4;
  localparam int V    = 3;
  localparam int AW   = 20;
  localparam int FW   = 8;
  localparam int XW   = 2;
  localparam int YW   = 2;
  localparam int E_W  = AW + XW + YW + 3;
`ifdef VGA_RASTER_DOUBLE_BUFFER_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif

  logic          clock;
  logic          reset;
  logic          start;
  logic          continuous;
  logic          abort;
  logic [FW-1:0] frame_count;
  logic          buf_sel;
  vga_state_t    state;

  vga_raster_addr_gen_if #(.ADDR_W(AW), .X_W(XW), .Y_W(YW)) pix ();

  vga_raster_addr_gen #(
    .H_ACTIVE (H),
    .V_ACTIVE (V),
    .ADDR_W   (AW),
    .BASE_ADDR(0),
    .FCNT_W   (FW)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .continuous (continuous),
    .abort      (abort),
    .pix        (pix),
    .frame_count(frame_count),
    .buf_sel    (buf_sel),
    .state      (state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;
  logic exp_buf = 1'b0;
  logic [E_W-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [E_W-1:0] observed();
    return {pix.read_address, pix.x, pix.y, pix.sof, pix.eol, pix.eof};
  endfunction

  // One frame of expected beats starting at the given buffer's base.
  task automatic push_frame(input logic b);
    for (int i = 0; i < H * V; i++) begin
      logic [AW-1:0] a;
      logic [XW-1:0] ex;
      logic [YW-1:0] ey;
      a  = AW'((b ? H * V : 0) + i);
      ex = XW'(i % H);
      ey = YW'(i / H);
      exp_q.push_back({a, ex, ey, (i == 0), (i % H == H - 1), (i == H * V - 1)});
    end
  endtask

  task automatic pulse_start();
    @(negedge clock);
    start = 1'b1;
    out_ready_set(1'b0);
  endtask

  task automatic out_ready_set(input logic r);
    pix.out_ready = r;
  endtask

  // Walk the expected queue; bp applies the 1,0,0,1 ready pattern.
  task automatic drain(input int max_acc, input bit bp, input int stop_cont_at);
    int acc = 0;
    int cyc = 0;
    logic rdy;
    logic [E_W-1:0] e;
    while (exp_q.size() > 0 && acc < max_acc && cyc < 200) begin
      @(negedge clock);
      start = 1'b0;
      rdy = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      if (stop_cont_at > 0 && exp_q.size() == stop_cont_at) continuous = 1'b0;
      out_ready_set(rdy);
      chk("valid", 32'(pix.out_valid), 32'd1);
      chk("beat", 32'(observed()), 32'(exp_q[0]));
      if (rdy) begin
        e = exp_q.pop_front();
        acc++;
        if (e[0]) exp_buf = exp_buf ^ DB;
      end
      cyc++;
    end
    if (cyc >= 200 && acc < max_acc) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    continuous = 1'b0;
    abort = 1'b0;
    pix.out_ready = 1'b0;

    // reset held three cycles
    repeat (3) @(negedge clock);
    chk("rst_valid", 32'(pix.out_valid), 32'd0);
    chk("rst_addr", 32'(pix.read_address), 32'd0);
    chk("rst_fcnt", 32'(frame_count), 32'd0);
    chk("rst_buf", 32'(buf_sel), 32'd0);
    chk("rst_xy", 32'({pix.x, pix.y}), 32'd0);
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    chk("idle_valid", 32'(pix.out_valid), 32'd0);
    chk("idle_state", 32'(state), 32'(IDLE));

    // single frame, full throughput
    push_frame(exp_buf);
    pulse_start();
    drain(100, 1'b0, 0);
    @(negedge clock);
    out_ready_set(1'b0);
    chk("single_end_valid", 32'(pix.out_valid), 32'd0);
    chk("single_fcnt", 32'(frame_count), 32'd1);
    chk("single_buf", 32'(buf_sel), 32'(exp_buf));

    // backpressure
    push_frame(exp_buf);
    pulse_start();
    drain(100, 1'b1, 0);
    @(negedge clock);
    out_ready_set(1'b0);
    chk("bp_end_valid", 32'(pix.out_valid), 32'd0);
    chk("bp_fcnt", 32'(frame_count), 32'd2);
    chk("bp_queue", 32'(exp_q.size()), 32'd0);

    // three continuous frames, stop requested during the third
    continuous = 1'b1;
    push_frame(exp_buf);
    push_frame(exp_buf ^ DB);
    push_frame(exp_buf);
    pulse_start();
    drain(100, 1'b0, 12);
    @(negedge clock);
    out_ready_set(1'b0);
    chk("cont_end_valid", 32'(pix.out_valid), 32'd0);
    chk("cont_fcnt", 32'(frame_count), 32'd5);
    chk("cont_buf", 32'(buf_sel), 32'(exp_buf));

    // abort at address base+5
    push_frame(exp_buf);
    pulse_start();
    drain(5, 1'b0, 0);
    @(negedge clock);
    chk("abort_at", 32'(pix.read_address), 32'(exp_buf ? 12 + 5 : 5));
    abort = 1'b1;
    out_ready_set(1'b1);
    @(negedge clock);
    abort = 1'b0;
    out_ready_set(1'b0);
    chk("abort_valid", 32'(pix.out_valid), 32'd0);
    chk("abort_addr", 32'(pix.read_address), 32'(exp_buf ? 12 : 0));
    chk("abort_xy", 32'({pix.x, pix.y}), 32'd0);
    chk("abort_fcnt", 32'(frame_count), 32'd5);
    chk("abort_buf", 32'(buf_sel), 32'(exp_buf));
    exp_q.delete();
    start = 1'b1;
    abort = 1'b1;
    @(negedge clock);
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_valid", 32'(pix.out_valid), 32'd0);

    // restart, then async reset at address base+7
    push_frame(exp_buf);
    pulse_start();
    drain(7, 1'b0, 0);
    @(negedge clock);
    out_ready_set(1'b0);
    chk("pre_reset_addr", 32'(pix.read_address), 32'(exp_buf ? 12 + 7 : 7));
    #2 reset = 1'b0;
    #1;
    chk("async_valid", 32'(pix.out_valid), 32'd0);
    chk("async_addr", 32'(pix.read_address), 32'd0);
    chk("async_xy", 32'({pix.x, pix.y}), 32'd0);
    chk("async_fcnt", 32'(frame_count), 32'd0);
    chk("async_buf", 32'(buf_sel), 32'd0);
    exp_q.delete();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
